// File: rtl/silife_grid_sequencer.sv
// silife_grid_sequencer: row load / N-generation run / 8-row dump controller for the SiLife grid.
// Optional SILIFE_SEQ_AUTODUMP_EN: a finished RUN falls straight into a full dump.
module silife_grid_sequencer #(
    parameter int GEN_W = 8,
    parameter int ROWS  = 8,
    localparam int RW   = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [RW-1:0] cmd_row,
    input  logic [7:0]    cmd_data,
    output logic          busy,
    output logic          gen_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_row,
    output logic [7:0]    out_data,
    output logic [RW-1:0] grid_row_select,
    output logic [7:0]    grid_set_cells,
    output logic [7:0]    grid_clr_cells,
    output logic          grid_enable,
    input  logic [7:0]    grid_cells
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_LDONE = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_SEL   = 3'd4;
    localparam logic [2:0] S_CAP   = 3'd5;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
`ifdef SILIFE_SEQ_AUTODUMP_EN
    localparam logic [2:0] S_AFTER_RUN = S_SEL;
`else
    localparam logic [2:0] S_AFTER_RUN = S_IDLE;
`endif

    logic [2:0]       state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [7:0]       data_q, data_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [RW-1:0]    r_q, r_d;
    logic             out_valid_q, out_valid_d;
    logic [RW-1:0]    out_row_q, out_row_d;
    logic [7:0]       out_data_q, out_data_d;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        data_d      = data_q;
        gen_d       = gen_q;
        r_d         = r_q;
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            state_d = S_LOAD;
                            row_d   = cmd_row;
                            data_d  = cmd_data;
                        end
                        OP_RUN: begin
                            state_d = S_RUN;
                            gen_d   = GEN_W'(cmd_data);
                        end
                        OP_DUMP: begin
                            state_d = S_SEL;
                            r_d     = '0;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_LOAD:  state_d = S_LDONE;
            S_LDONE: state_d = S_IDLE;
            S_RUN: begin
                state_d = (gen_q == '0) ? S_AFTER_RUN : S_RUN;
                gen_d   = (gen_q == '0) ? gen_q : gen_q - GEN_W'(1);
                r_d     = '0;
            end
            S_SEL: begin
                state_d     = S_CAP;
                out_valid_d = 1'b1;
                out_row_d   = r_q;
                out_data_d  = grid_cells;
            end
            S_CAP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = (r_q == LAST_ROW) ? S_IDLE : S_SEL;
                    r_d         = (r_q == LAST_ROW) ? '0 : r_q + RW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            data_q      <= '0;
            gen_q       <= '0;
            r_q         <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            data_q      <= data_d;
            gen_q       <= gen_d;
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_data_q  <= out_data_d;
        end
    end

    // Grid drives are decoded from state so enable and set/clr can never overlap.
    assign cmd_ready       = (state_q == S_IDLE);
    assign busy            = ~cmd_ready;
    assign gen_done        = (state_q == S_RUN) && (gen_q == '0);
    assign grid_enable     = (state_q == S_RUN);
    assign grid_set_cells  = (state_q == S_LOAD) ? data_q : '0;
    assign grid_clr_cells  = (state_q == S_LOAD) ? ~data_q : '0;
    assign grid_row_select = (state_q == S_LOAD) ? row_q :
                             (state_q == S_SEL || state_q == S_CAP) ? r_q : '0;
    assign out_valid       = out_valid_q;
    assign out_row         = out_row_q;
    assign out_data        = out_data_q;
endmodule

// File: tb/tb_silife_grid_sequencer.sv
// tb_silife_grid_sequencer: scoreboard bench for the SiLife grid sequencer with a behavioural 8x8 Life grid.
module tb_silife_grid_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_row = 3'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       busy, gen_done, out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_row, grid_row_select;
    logic [7:0] out_data, grid_set_cells, grid_clr_cells, grid_cells;
    logic       grid_enable;
    logic [63:0] gm = '0;

    typedef struct packed {
        logic [2:0] row;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    silife_grid_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_data(cmd_data),
        .busy(busy), .gen_done(gen_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data),
        .grid_row_select(grid_row_select), .grid_set_cells(grid_set_cells),
        .grid_clr_cells(grid_clr_cells), .grid_enable(grid_enable), .grid_cells(grid_cells)
    );

    function automatic logic [63:0] life(input logic [63:0] g);
        logic [63:0] n;
        int k;
        n = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                k = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8 && g[(r + dr) * 8 + c + dc])
                            k++;
                n[r * 8 + c] = (k == 3) || (k == 2 && g[r * 8 + c]);
            end
        return n;
    endfunction

    function automatic logic [7:0] pat(input int r);
        return 8'(r * 37 + 5);
    endfunction

    // Dead-boundary Life grid: enable advances a generation, otherwise set/clr write the selected row.
    assign grid_cells = gm[{grid_row_select, 3'b000} +: 8];
    always @(posedge clk) begin
        if (grid_enable)
            gm <= life(gm);
        else
            gm[{grid_row_select, 3'b000} +: 8] <= (gm[{grid_row_select, 3'b000} +: 8] | grid_set_cells) & ~grid_clr_cells;
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] row, input logic [7:0] data);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            miscompares++;
            $display("FAIL issue_timeout cmd_ready=%b required 1", cmd_ready);
        end
        cmd_op = op;
        cmd_row = row;
        cmd_data = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [34:0] got, req;
        reset = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        cmd_row = 3'd3;
        cmd_data = 8'hFF;
        req = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 8'd0, 8'd0, 1'b0};
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            got = {cmd_ready, busy, gen_done, out_valid, out_row, out_data,
                   grid_row_select, grid_set_cells, grid_clr_cells, grid_enable};
            vectors++;
            if (got !== req) begin
                miscompares++;
                $display("FAIL reset_outputs got %h required %h", got, req);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (gm !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_no_write grid %h required 0", gm);
        end
    endtask

    task automatic test_load();
        issue(2'b01, 3'd3, 8'hA5);
        vectors++;
        if ({grid_row_select, grid_set_cells, grid_clr_cells, grid_enable, cmd_ready} !== {3'd3, 8'hA5, 8'h5A, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL load_write sel=%0d set=%h clr=%h en=%b rdy=%b required 3 a5 5a 0 0",
                     grid_row_select, grid_set_cells, grid_clr_cells, grid_enable, cmd_ready);
        end
        @(negedge clk);
        vectors++;
        if ({grid_set_cells, grid_clr_cells, grid_enable, cmd_ready} !== {8'h00, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL load_idle set=%h clr=%h en=%b rdy=%b required 00 00 0 0",
                     grid_set_cells, grid_clr_cells, grid_enable, cmd_ready);
        end
        @(negedge clk);
        vectors++;
        if ({cmd_ready, gm[24 +: 8]} !== {1'b1, 8'hA5}) begin
            miscompares++;
            $display("FAIL load_done rdy=%b row3=%h required 1 a5", cmd_ready, gm[24 +: 8]);
        end
    endtask

    task automatic test_run();
        int cnt, first, last, dn, dk, bad;
        issue(2'b01, 3'd3, 8'h1C);
        issue(2'b10, 3'd0, 8'd4);
        cnt = 0; first = -1; last = -1; dn = 0; dk = -1; bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (grid_enable) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
                if ((grid_set_cells | grid_clr_cells) != 8'd0) bad++;
            end
            if (gen_done) begin
                dn++;
                dk = k;
            end
            @(negedge clk);
        end
        vectors++;
        if (cnt != 5 || first != 0 || last != 4) begin
            miscompares++;
            $display("FAIL run_enable count=%0d first=%0d last=%0d required 5 0 4", cnt, first, last);
        end
        vectors++;
        if (dn != 1 || dk != 4) begin
            miscompares++;
            $display("FAIL run_gen_done pulses=%0d at=%0d required 1 at 4", dn, dk);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL run_no_write overlaps=%0d required 0", bad);
        end
`ifdef SILIFE_SEQ_AUTODUMP_EN
        vectors++;
        if ({busy, cmd_ready, out_valid, out_row} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL run_autodump busy=%b rdy=%b ov=%b row=%0d required 1 0 1 0",
                     busy, cmd_ready, out_valid, out_row);
        end
`else
        vectors++;
        if ({busy, cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL run_idle busy=%b rdy=%b required 0 1", busy, cmd_ready);
        end
`endif
    endtask

    task automatic test_dump();
        exp_t e;
        int k, prev;
        sb.delete();
        for (int r = 0; r < 8; r++) begin
            e.row = 3'(r);
            e.data = (r >= 2 && r <= 4) ? 8'h08 : 8'h00;
            sb.push_back(e);
        end
        out_ready = 1'b1;
`ifndef SILIFE_SEQ_AUTODUMP_EN
        issue(2'b11, 3'd0, 8'd0);
`endif
        k = 0;
        prev = -1;
        while (sb.size() > 0 && k < 60) begin
            if (out_valid) begin
                e = sb.pop_front();
                vectors++;
                if ({out_row, out_data} !== {e.row, e.data}) begin
                    miscompares++;
                    $display("FAIL dump_row got row %0d data %h required row %0d data %h", out_row, out_data, e.row, e.data);
                end
                if (prev >= 0) begin
                    vectors++;
                    if (k - prev != 2) begin
                        miscompares++;
                        $display("FAIL dump_spacing got %0d cycles required 2", k - prev);
                    end
                end
                prev = k;
            end
            @(negedge clk);
            k++;
        end
        vectors++;
        if (sb.size() != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL dump_end left=%0d busy=%b ov=%b required 0 0 0", sb.size(), busy, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        cmd_op = 2'b01;
        for (int r = 0; r < 8; r++) begin
            cmd_row = 3'(r);
            cmd_data = pat(r);
            cmd_valid = 1'b1;
            n = 0;
            while (!cmd_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n = 0;
        while (!cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int r = 0; r < 8; r++) begin
            vectors++;
            if (gm[r * 8 +: 8] !== pat(r)) begin
                miscompares++;
                $display("FAIL b2b_row%0d got %h required %h", r, gm[r * 8 +: 8], pat(r));
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int k;
        bit stalled;
        sb.delete();
        for (int r = 0; r < 8; r++) begin
            e.row = 3'(r);
            e.data = pat(r);
            sb.push_back(e);
        end
        out_ready = 1'b1;
        issue(2'b11, 3'd0, 8'd0);
        k = 0;
        stalled = 1'b0;
        while (sb.size() > 0 && k < 100) begin
            if (out_valid && out_row == 3'd2 && !stalled) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                for (int j = 0; j < 10; j++) begin
                    @(negedge clk);
                    vectors++;
                    if ({out_valid, out_row, out_data, grid_row_select} !== {1'b1, 3'd2, pat(2), 3'd2}) begin
                        miscompares++;
                        $display("FAIL stall_hold ov=%b row=%0d data=%h sel=%0d required 1 2 %h 2",
                                 out_valid, out_row, out_data, grid_row_select, pat(2));
                    end
                end
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                vectors++;
                if ({out_row, out_data} !== {e.row, e.data}) begin
                    miscompares++;
                    $display("FAIL stall_row got row %0d data %h required row %0d data %h", out_row, out_data, e.row, e.data);
                end
            end
            @(negedge clk);
            k++;
        end
        vectors++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_end left=%0d busy=%b required 0 0", sb.size(), busy);
        end
    endtask

    task automatic test_reset_run();
        int cnt, k, dn;
        issue(2'b10, 3'd0, 8'd200);
        cnt = 0; k = 0; dn = 0;
        while (cnt < 100 && k < 150) begin
            if (grid_enable) cnt++;
            if (gen_done) dn++;
            @(negedge clk);
            k++;
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({grid_enable, busy, cmd_ready, gen_done} !== 4'b0010 || cnt != 100 || dn != 0) begin
            miscompares++;
            $display("FAIL reset_run en=%b busy=%b rdy=%b done=%b gens=%0d pulses=%0d required 0 0 1 0 100 0",
                     grid_enable, busy, cmd_ready, gen_done, cnt, dn);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({grid_enable, gen_done, cmd_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_run_after en=%b done=%b rdy=%b required 0 0 1", grid_enable, gen_done, cmd_ready);
        end
    endtask

`ifdef SILIFE_SEQ_AUTODUMP_EN
    task automatic test_autodump();
        exp_t e;
        int k, early;
        out_ready = 1'b1;
        issue(2'b10, 3'd0, 8'd0);
        vectors++;
        if ({grid_enable, gen_done} !== 2'b11) begin
            miscompares++;
            $display("FAIL auto_run en=%b done=%b required 1 1", grid_enable, gen_done);
        end
        @(negedge clk);
        vectors++;
        if (grid_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL auto_one_gen en=%b required 0", grid_enable);
        end
        sb.delete();
        for (int r = 0; r < 8; r++) begin
            e.row = 3'(r);
            e.data = gm[r * 8 +: 8];
            sb.push_back(e);
        end
        k = 0;
        early = 0;
        while (sb.size() > 0 && k < 40) begin
            if (cmd_ready) early++;
            if (out_valid) begin
                e = sb.pop_front();
                vectors++;
                if ({out_row, out_data} !== {e.row, e.data}) begin
                    miscompares++;
                    $display("FAIL auto_row got row %0d data %h required row %0d data %h", out_row, out_data, e.row, e.data);
                end
            end
            @(negedge clk);
            k++;
        end
        vectors++;
        if (sb.size() != 0 || early != 0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL auto_end left=%0d early_ready=%0d rdy=%b required 0 0 1", sb.size(), early, cmd_ready);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_run();
        test_dump();
        test_back_to_back();
        test_stall();
        test_reset_run();
`ifdef SILIFE_SEQ_AUTODUMP_EN
        test_autodump();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
